// File: rtl/num_pkg.sv
// num_pkg: shared definitions for the num_feeder block.
//   PERIOD_W - width of the inter-pulse gap (period input and gap_timer counter)
//   COUNT_W  - width of the emitted-value counter (covers BURST_LEN up to 255)
//   state_e  - feeder FSM encoding: IDLE=0, RUN=1, WAIT=2, DONE=3
package num_pkg;

    localparam int unsigned PERIOD_W = 4;
    localparam int unsigned COUNT_W  = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } state_e;

endpackage

// File: rtl/gap_timer.sv
// gap_timer: down-counter that times the idle gap between enable pulses.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   load     - load load_val into the counter (start of a gap)
//   load_val - number of gap cycles to time
//   tick     - one gap cycle has elapsed
//   expire   - asserted together with the tick of the final gap cycle
module gap_timer
    import num_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [PERIOD_W-1:0] load_val,
    input  logic                tick,
    output logic                expire
);

    localparam logic [PERIOD_W-1:0] One = PERIOD_W'(1);

    logic [PERIOD_W-1:0] remaining_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining_q <= '0;
        end else if (load) begin
            remaining_q <= load_val;
        end else if (tick && remaining_q != '0) begin
            remaining_q <= remaining_q - One;
        end
    end

    // A zero count is treated as expired so a stray zero load can never stall the feeder.
    assign expire = tick && (remaining_q == One || remaining_q == '0);

endmodule

// File: rtl/num_feeder.sv
// num_feeder: emits bursts of BURST_LEN arithmetic-sequence values to a downstream
// rotator, one value per enable strobe, with a programmable gap between strobes.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   start  - burst request, sampled only in IDLE
//   stop   - abort request, honoured in any state (wins over start)
//   seed   - first value of the burst
//   step   - increment between values (wraps mod 2^WIDTH)
//   period - idle cycles between successive enable pulses
//   numout - registered value, valid when enable=1, held between pulses
//   enable - registered single-cycle valid strobe
//   busy   - high in RUN and WAIT
//   done   - one-cycle pulse on normal burst completion
// Build option: define NUM_FEEDER_GRAY_EN to present numout as the Gray code of the
// internal value; arithmetic and timing are unchanged.
module num_feeder
    import num_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned BURST_LEN = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic [WIDTH-1:0]    seed,
    input  logic [WIDTH-1:0]    step,
    input  logic [PERIOD_W-1:0] period,
    output logic [WIDTH-1:0]    numout,
    output logic                enable,
    output logic                busy,
    output logic                done
);

    if (BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_burst_len
        $error("num_feeder: BURST_LEN must be in 1..255");
    end

    localparam logic [COUNT_W-1:0] BurstLast = COUNT_W'(BURST_LEN);

    state_e              state_q;
    logic [WIDTH-1:0]    value_q;
    logic [WIDTH-1:0]    step_q;
    logic [PERIOD_W-1:0] period_q;
    logic [COUNT_W-1:0]  count_q;

    logic [WIDTH-1:0]    next_value;
    logic [WIDTH-1:0]    seed_out;
    logic [WIDTH-1:0]    next_out;
    logic [COUNT_W-1:0]  count_inc;
    logic                last_value;
    logic                timer_load;
    logic                timer_tick;
    logic                timer_expire;

    assign next_value = value_q + step_q;
    assign count_inc  = count_q + COUNT_W'(1);
    assign last_value = (count_inc == BurstLast);

`ifdef NUM_FEEDER_GRAY_EN
    assign seed_out = seed ^ (seed >> 1);
    assign next_out = next_value ^ (next_value >> 1);
`else
    assign seed_out = seed;
    assign next_out = next_value;
`endif

    // Load the gap on the RUN cycle that is followed by a WAIT; tick on every WAIT cycle.
    assign timer_load = (state_q == StRun) && !stop && !last_value && (period_q != '0);
    assign timer_tick = (state_q == StWait);

    gap_timer u_gap_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (period_q),
        .tick     (timer_tick),
        .expire   (timer_expire)
    );

    // The registered enable is raised on the edge that enters RUN, so enable=1
    // exactly during the RUN cycles and numout only changes on those edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            value_q  <= '0;
            step_q   <= '0;
            period_q <= '0;
            count_q  <= '0;
            numout   <= '0;
            enable   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            enable <= 1'b0;
            done   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start && !stop) begin
                        value_q  <= seed;
                        step_q   <= step;
                        period_q <= period;
                        count_q  <= '0;
                        numout   <= seed_out;
                        enable   <= 1'b1;
                        busy     <= 1'b1;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    count_q <= count_inc;
                    if (stop) begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else if (last_value) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else if (period_q == '0) begin
                        value_q <= next_value;
                        numout  <= next_out;
                        enable  <= 1'b1;
                    end else begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (stop) begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else if (timer_expire) begin
                        value_q <= next_value;
                        numout  <= next_out;
                        enable  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_num_feeder.sv
module tb_num_feeder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] seed = 4'd0;
    logic [3:0] step = 4'd0;
    logic [3:0] period = 4'd0;
    logic [3:0] numout;
    logic       enable;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;

    logic [3:0] exp_q[$];
    logic [3:0] obs_q[$];
    int         obs_cyc[$];

    num_feeder #(
        .WIDTH     (4),
        .BURST_LEN (8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .stop   (stop),
        .seed   (seed),
        .step   (step),
        .period (period),
        .numout (numout),
        .enable (enable),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobed value with the cycle it appeared in.
    always @(negedge clk) begin
        if (enable) begin
            obs_q.push_back(numout);
            obs_cyc.push_back(cyc);
        end
        if (done) done_cnt++;
    end

    function automatic logic [3:0] enc(input logic [3:0] v);
`ifdef NUM_FEEDER_GRAY_EN
        return v ^ (v >> 1);
`else
        return v;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_queues();
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
    endtask

    task automatic push_burst(input logic [3:0] s, input logic [3:0] st, input int n);
        logic [3:0] v;
        v = s;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(enc(v));
            v = v + st;
        end
    endtask

    task automatic go(input logic [3:0] s, input logic [3:0] st, input logic [3:0] p);
        seed = s;
        step = st;
        period = p;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_tests++;
        if ({numout, enable, busy, done} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, expected 0000000", {numout, enable, busy, done});
        end
        rst_n = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({enable, busy, done} !== 3'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got %b, expected 000", {enable, busy, done});
        end
    endtask

    task automatic test_basic();
        logic [3:0] e, o;
        int d0;
        clear_queues();
        d0 = done_cnt;
        push_burst(4'd3, 4'd2, 8);
        go(4'd3, 4'd2, 4'd0);
        n_tests++;
        if (enable !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_latency: got enable=%b busy=%b, expected 1 1", enable, busy);
        end
        repeat (8) tick();
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: got done=%b busy=%b, expected 1 0", done, busy);
        end
        tick();
        n_tests++;
        if (done !== 1'b0 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL basic_done_pulse: got done=%b pulses=%0d, expected 0 1", done, done_cnt - d0);
        end
        for (int i = 1; i < obs_cyc.size(); i++) begin
            n_tests++;
            if (obs_cyc[i] - obs_cyc[i-1] != 1) begin
                n_fail++;
                $display("FAIL basic_spacing: got %0d, expected 1", obs_cyc[i] - obs_cyc[i-1]);
            end
        end
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL basic_count: got %0d enables, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL basic_value: got %h, expected %h", o, e);
            end
        end
    endtask

    task automatic test_pacing();
        logic [3:0] e, o, last;
        bit seen_done;
        clear_queues();
        push_burst(4'd1, 4'd1, 8);
        go(4'd1, 4'd1, 4'd2);
        last = numout;
        seen_done = 1'b0;
        for (int i = 0; i < 30 && !seen_done; i++) begin
            if (enable) begin
                last = numout;
            end else if (busy) begin
                n_tests++;
                if (numout !== last) begin
                    n_fail++;
                    $display("FAIL pacing_hold: got %h, expected %h", numout, last);
                end
            end
            if (done) seen_done = 1'b1;
            else tick();
        end
        n_tests++;
        if (!seen_done) begin
            n_fail++;
            $display("FAIL pacing_done: got no done within 30 cycles, expected done");
        end
        tick();
        for (int i = 1; i < obs_cyc.size(); i++) begin
            n_tests++;
            if (obs_cyc[i] - obs_cyc[i-1] != 3) begin
                n_fail++;
                $display("FAIL pacing_spacing: got %0d, expected 3", obs_cyc[i] - obs_cyc[i-1]);
            end
        end
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL pacing_count: got %0d enables, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL pacing_value: got %h, expected %h", o, e);
            end
        end
    endtask

    task automatic test_abort();
        logic [3:0] e, o;
        int d0;
        clear_queues();
        d0 = done_cnt;
        push_burst(4'd0, 4'd1, 3);
        go(4'd0, 4'd1, 4'd2);
        repeat (7) tick();
        n_tests++;
        if (busy !== 1'b1 || enable !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_in_wait: got busy=%b enable=%b, expected 1 0", busy, enable);
        end
        stop = 1'b1;
        tick();
        n_tests++;
        if (busy !== 1'b0 || enable !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_busy: got busy=%b enable=%b, expected 0 0", busy, enable);
        end
        stop = 1'b0;
        repeat (10) tick();
        n_tests++;
        if (done_cnt != d0) begin
            n_fail++;
            $display("FAIL abort_done: got %0d pulses, expected 0", done_cnt - d0);
        end
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL abort_count: got %0d enables, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL abort_value: got %h, expected %h", o, e);
            end
        end
    endtask

    task automatic test_collision();
        clear_queues();
        seed = 4'd7;
        step = 4'd1;
        period = 4'd0;
        start = 1'b1;
        stop = 1'b1;
        tick();
        n_tests++;
        if (busy !== 1'b0 || enable !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_idle: got busy=%b enable=%b, expected 0 0", busy, enable);
        end
        start = 1'b0;
        stop = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (obs_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_no_enable: got %0d enables busy=%b, expected 0 0",
                     obs_q.size(), busy);
        end
    endtask

    // Seed 5 step 1: Gray build expects 7,5,4,C,D,F,E,A. Start is held high with a
    // different seed during the burst and must be ignored.
    task automatic test_gray();
        logic [3:0] e, o;
        clear_queues();
        push_burst(4'd5, 4'd1, 8);
        go(4'd5, 4'd1, 4'd0);
        start = 1'b1;
        seed = 4'd9;
        repeat (7) tick();
        start = 1'b0;
        tick();
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL gray_done: got %b, expected 1", done);
        end
        tick();
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL gray_count: got %0d enables, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL gray_value: got %h, expected %h", o, e);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] e, o;
        clear_queues();
        push_burst(4'd2, 4'd3, 3);
        go(4'd2, 4'd3, 4'd0);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({numout, enable, busy, done} !== 7'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %b, expected 0000000", {numout, enable, busy, done});
        end
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL async_count: got %0d enables, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL async_value: got %h, expected %h", o, e);
            end
        end
        clear_queues();
        #3;
        rst_n = 1'b1;
        repeat (8) tick();
        n_tests++;
        if (obs_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_after_release: got %0d enables busy=%b, expected 0 0",
                     obs_q.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pacing();
        test_abort();
        test_collision();
        test_gray();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
